// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved EX-stage branch/jump into a PC redirect handshake toward fetch,
// flushes the wrong-path pipeline registers and arbitrates against load-use stalls.
module branch_redirect_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [1:0]       ex_br_taken,
   input  logic [31:0]      ex_target,
   input  logic             id_load_use,
   input  logic             fetch_ready,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             stall_if,
   output logic             stall_id,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] jmp_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] drain_cnt, drain_cnt_nxt;
   logic       is_br, is_jmp, event_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Code 11 is reserved and behaves like not-taken.
   assign is_br     = ex_valid && (ex_br_taken == 2'b01);
   assign is_jmp    = ex_valid && (ex_br_taken == 2'b10);
   assign event_hit = (state == IDLE) && (is_br || is_jmp);

   // rst_n gating keeps the stall outputs low while reset is held.
   assign stall_if = rst_n & id_load_use & (state == IDLE) & ~event_hit;
   assign stall_id = stall_if;

   always_comb begin
      state_nxt      = state;
      drain_cnt_nxt  = drain_cnt;
      redirect_valid = 1'b0;
      flush_ifid     = 1'b0;
      flush_idex     = 1'b0;
      case (state)
         IDLE: begin
            if (event_hit) state_nxt = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
            if (fetch_ready) begin
               if (FLUSH_CYCLES == 0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = DRAIN_INIT;
               end
            end
         end
         DRAIN: begin
            flush_ifid = 1'b1;
            if (drain_cnt == 4'd0) state_nxt = IDLE;
            else                   drain_cnt_nxt = drain_cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         drain_cnt   <= 4'd0;
         redirect_pc <= 32'd0;
         br_cnt      <= '0;
         jmp_cnt     <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (event_hit) begin
            redirect_pc <= ex_target;
            if (is_br)  br_cnt  <= sat_inc(br_cnt);
            if (is_jmp) jmp_cnt <= sat_inc(jmp_cnt);
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a default build (FLUSH_CYCLES=2) and a
// FLUSH_CYCLES=0 / CNT_W=4 build, with redirect handshakes checked from queues.
module tb_branch_redirect_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default build
   logic        a_valid, a_lu, a_fr;
   logic [1:0]  a_tk;
   logic [31:0] a_tgt, a_pc;
   logic        a_rv, a_fi, a_fx, a_sif, a_sid;
   logic [31:0] a_br, a_jmp;

   // FLUSH_CYCLES=0, CNT_W=4 build
   logic        b_valid, b_lu, b_fr;
   logic [1:0]  b_tk;
   logic [31:0] b_tgt, b_pc;
   logic        b_rv, b_fi, b_fx, b_sif, b_sid;
   logic [3:0]  b_br, b_jmp;

   branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .ex_valid(a_valid), .ex_br_taken(a_tk), .ex_target(a_tgt),
      .id_load_use(a_lu), .fetch_ready(a_fr), .redirect_valid(a_rv), .redirect_pc(a_pc),
      .flush_ifid(a_fi), .flush_idex(a_fx), .stall_if(a_sif), .stall_id(a_sid),
      .br_cnt(a_br), .jmp_cnt(a_jmp));

   branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .ex_valid(b_valid), .ex_br_taken(b_tk), .ex_target(b_tgt),
      .id_load_use(b_lu), .fetch_ready(b_fr), .redirect_valid(b_rv), .redirect_pc(b_pc),
      .flush_ifid(b_fi), .flush_idex(b_fx), .stall_if(b_sif), .stall_id(b_sid),
      .br_cnt(b_br), .jmp_cnt(b_jmp));

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] br;
      logic [31:0] jmp;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: one expected record per accepted redirect handshake.
   always @(negedge clk) begin
      if (rst_n && a_rv && a_fr) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_redirect: got pc %0h, expected no redirect", a_pc);
         end else begin
            ea = qa.pop_front();
            chk("a_redirect_pc", a_pc, ea.pc);
            chk("a_br_cnt", a_br, ea.br);
            chk("a_jmp_cnt", a_jmp, ea.jmp);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_rv && b_fr) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_redirect: got pc %0h, expected no redirect", b_pc);
         end else begin
            eb = qb.pop_front();
            chk("b_redirect_pc", b_pc, eb.pc);
            chk("b_br_cnt", b_br, eb.br);
            chk("b_jmp_cnt", b_jmp, eb.jmp);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] nk [3];
      logic       nv [3];
      rst_n = 1'b0;
      a_valid = 0; a_tk = 2'b00; a_tgt = 0; a_lu = 1; a_fr = 0;
      b_valid = 0; b_tk = 2'b00; b_tgt = 0; b_lu = 0; b_fr = 0;

      // reset state
      @(negedge clk);
      chk("rst_redirect_valid", a_rv, 0);
      chk("rst_flushes", {a_fi, a_fx}, 0);
      chk("rst_stalls", {a_sif, a_sid}, 0);
      chk("rst_pc", a_pc, 0);
      chk("rst_counters", {a_br, a_jmp}, 0);
      next_cycle();
      rst_n = 1'b1;

      // load-use stall alone
      @(negedge clk);
      chk("stall_only", {a_sif, a_sid}, 2'b11);
      chk("stall_only_rv", a_rv, 0);

      // conditional taken coinciding with load-use
      next_cycle();
      a_valid = 1; a_tk = 2'b01; a_tgt = 32'h0000_0100; a_fr = 1;
      qa.push_back('{pc: 32'h100, br: 1, jmp: 0});
      @(negedge clk);
      chk("event_stall_suppressed", {a_sif, a_sid}, 2'b00);
      chk("event_cycle_rv", a_rv, 0);
      next_cycle();
      a_valid = 0;
      @(negedge clk);
      chk("br_redirect_outs", {a_rv, a_fi, a_fx}, 3'b111);
      chk("br_redirect_stall", {a_sif, a_sid}, 2'b00);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge clk);
         chk("br_drain_outs", {a_rv, a_fi, a_fx}, 3'b010);
         chk("br_drain_stall", {a_sif, a_sid}, 2'b00);
      end
      next_cycle();
      @(negedge clk);
      chk("br_back_idle", {a_rv, a_fi, a_fx}, 3'b000);
      chk("br_idle_stall", {a_sif, a_sid}, 2'b11);

      // jump with fetch backpressure; second event during wait ignored
      next_cycle();
      a_lu = 0; a_fr = 0; a_valid = 1; a_tk = 2'b10; a_tgt = 32'h2000_0040;
      qa.push_back('{pc: 32'h2000_0040, br: 1, jmp: 1});
      next_cycle();
      a_tk = 2'b01; a_tgt = 32'h0000_DEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("jmp_wait_rv", a_rv, 1);
         chk("jmp_wait_pc", a_pc, 32'h2000_0040);
         chk("jmp_wait_cnts", {a_br, a_jmp}, {32'd1, 32'd1});
         next_cycle();
      end
      a_valid = 0; a_fr = 1;
      @(negedge clk);
      chk("jmp_handshake_rv", a_rv, 1);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge clk);
         chk("jmp_drain_outs", {a_rv, a_fi, a_fx}, 3'b010);
      end
      next_cycle();
      @(negedge clk);
      chk("jmp_idle_outs", {a_rv, a_fi, a_fx}, 3'b000);

      // non-events leave everything idle
      nk[0] = 2'b00; nv[0] = 1'b1;
      nk[1] = 2'b11; nv[1] = 1'b1;
      nk[2] = 2'b01; nv[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         a_valid = nv[i]; a_tk = nk[i]; a_tgt = 32'h0000_0500;
         next_cycle();
         a_valid = 0;
         @(negedge clk);
         chk("nonevent_outs", {a_rv, a_fi, a_fx}, 3'b000);
         chk("nonevent_cnts", {a_br, a_jmp}, {32'd1, 32'd1});
      end

      // reset while waiting in REDIRECT
      next_cycle();
      a_valid = 1; a_tk = 2'b01; a_tgt = 32'h0000_0300; a_fr = 0;
      next_cycle();
      a_valid = 0; a_lu = 1;
      @(negedge clk);
      chk("abort_pre_rv", a_rv, 1);
      chk("abort_pre_br", a_br, 2);
      next_cycle();
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {a_rv, a_fi, a_fx, a_sif, a_sid}, 5'b00000);
      chk("abort_pc", a_pc, 0);
      chk("abort_cnts", {a_br, a_jmp}, 0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle_outs", {a_rv, a_fi, a_fx}, 3'b000);
      chk("abort_idle_stall", {a_sif, a_sid}, 2'b11);
      a_lu = 0;

      // FLUSH_CYCLES=0: back-to-back events every 2 cycles, 4-bit counter saturates
      b_fr = 1; b_lu = 1; b_tk = 2'b01;
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         b_valid = 1; b_tgt = 32'h1000 + 32'(i * 4);
         qb.push_back('{pc: 32'h1000 + 32'(i * 4), br: (i + 1 > 15) ? 15 : i + 1, jmp: 0});
         @(negedge clk);
         chk("b_event_idle_rv", b_rv, 0);
         chk("b_event_stall", {b_sif, b_sid}, 2'b00);
         next_cycle();
         b_tgt = 32'h0000_0BAD;
         @(negedge clk);
         chk("b_redirect_outs", {b_rv, b_fi, b_fx}, 3'b111);
      end
      next_cycle();
      b_valid = 0;
      @(negedge clk);
      chk("b_final_idle", {b_rv, b_fi, b_fx}, 3'b000);
      chk("b_sat_br", b_br, 4'hF);
      chk("b_jmp_zero", b_jmp, 0);
      chk("b_idle_stall", {b_sif, b_sid}, 2'b11);

      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish, expected finish before 50000");
      $fatal(1);
   end

endmodule
